// File: rtl/sm_regdump_uart_pkg.sv
// Shared constants, FSM encoding and byte-formatting helpers for the register dump UART.
package sm_regdump_uart_pkg;

    localparam int unsigned FrameBits      = 10;
    localparam int unsigned RawBytesPerReg = 4;
    localparam int unsigned HexBytesPerReg = 10;
    localparam logic [7:0]  AsciiCr        = 8'h0D;
    localparam logic [7:0]  AsciiLf        = 8'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StSetAddr,
        StSend,
        StNext,
        StFinish
    } regdumpState_e;

    function automatic logic [7:0] hexChar(logic [3:0] nibble);
        return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    endfunction

    // Raw mode: byte idx of the word, MSB byte first.
    function automatic logic [7:0] rawByte(logic [31:0] word, logic [3:0] idx);
        case (idx)
            4'd0:    return word[31:24];
            4'd1:    return word[23:16];
            4'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

    // Hex mode: eight nibbles MSB first, then CR, LF.
    function automatic logic [7:0] hexByte(logic [31:0] word, logic [3:0] idx);
        case (idx)
            4'd0:    return hexChar(word[31:28]);
            4'd1:    return hexChar(word[27:24]);
            4'd2:    return hexChar(word[23:20]);
            4'd3:    return hexChar(word[19:16]);
            4'd4:    return hexChar(word[15:12]);
            4'd5:    return hexChar(word[11:8]);
            4'd6:    return hexChar(word[7:4]);
            4'd7:    return hexChar(word[3:0]);
            4'd8:    return AsciiCr;
            default: return AsciiLf;
        endcase
    endfunction

endpackage

// File: rtl/sm_regdump_uart_tx.sv
// UART 8N1 transmitter: baud counter plus frame shifter with a valid/ready byte handshake.
module sm_regdump_uart_tx
    import sm_regdump_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       txValid_i,
    input  logic [7:0] txData_i,
    output logic       txReady_o,
    output logic       txIdle_o,
    output logic       txLine_o
);

    localparam int unsigned BaudW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [BaudW-1:0] baudCnt_q;
    logic [3:0]       bitCnt_q;
    logic [8:0]       shift_q;
    logic             active_q;
    logic             line_q;
    logic             bitEnd;
    logic             frameEnd;

    assign bitEnd   = (baudCnt_q == BaudW'(CLK_DIV - 1));
    assign frameEnd = active_q && bitEnd && (bitCnt_q == 4'(FrameBits - 1));
    // Ready in the last stop-bit cycle too, so frames chain with no idle gap.
    assign txReady_o = !active_q || frameEnd;
    assign txIdle_o  = !active_q;
    assign txLine_o  = line_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            active_q  <= 1'b0;
            line_q    <= 1'b1;
        end else if (txValid_i && txReady_o) begin
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            shift_q   <= {1'b1, txData_i};
            active_q  <= 1'b1;
            line_q    <= 1'b0;
        end else if (active_q) begin
            if (bitEnd) begin
                baudCnt_q <= '0;
                if (bitCnt_q == 4'(FrameBits - 1)) begin
                    active_q <= 1'b0;
                    line_q   <= 1'b1;
                end else begin
                    line_q   <= shift_q[0];
                    shift_q  <= {1'b1, shift_q[8:1]};
                    bitCnt_q <= bitCnt_q + 4'd1;
                end
            end else begin
                baudCnt_q <= baudCnt_q + BaudW'(1);
            end
        end
    end

endmodule

// File: rtl/sm_regdump_uart.sv
// Register dump initiator: walks FIRST_REG..LAST_REG on the debug port and sends each value
// over UART 8N1. Define SM_REGDUMP_HEX_EN for ASCII hex + CR/LF instead of raw bytes.
module sm_regdump_uart
    import sm_regdump_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

`ifdef SM_REGDUMP_HEX_EN
    localparam int unsigned BytesPerReg = HexBytesPerReg;
`else
    localparam int unsigned BytesPerReg = RawBytesPerReg;
`endif
    localparam logic [4:0] FirstAddr = 5'(FIRST_REG);
    localparam logic [4:0] LastAddr  = 5'(LAST_REG);
    localparam logic [3:0] LastByte  = 4'(BytesPerReg - 1);

    if (FIRST_REG > LAST_REG || LAST_REG > 31 || CLK_DIV < 2) begin : gen_param_check
        $error("sm_regdump_uart: need FIRST_REG <= LAST_REG <= 31 and CLK_DIV >= 2");
    end

    function automatic logic [7:0] pickByte(logic [31:0] word, logic [3:0] idx);
`ifdef SM_REGDUMP_HEX_EN
        return hexByte(word, idx);
`else
        return rawByte(word, idx);
`endif
    endfunction

    regdumpState_e state_q;
    logic [31:0]   dumpWord_q;
    logic [3:0]    byteCnt_q;
    logic          txValid_q;
    logic [7:0]    txData_q;
    logic          txReady;
    logic          txIdle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            dumpWord_q <= '0;
            byteCnt_q  <= '0;
            txValid_q  <= 1'b0;
            txData_q   <= '0;
            regAddr    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        regAddr <= FirstAddr;
                        busy    <= 1'b1;
                        state_q <= StSetAddr;
                    end
                end
                // regData has settled for a full cycle by the edge leaving this state.
                StSetAddr: begin
                    dumpWord_q <= regData;
                    byteCnt_q  <= '0;
                    txData_q   <= pickByte(regData, 4'd0);
                    txValid_q  <= 1'b1;
                    state_q    <= StSend;
                end
                StSend: begin
                    if (txValid_q && txReady) begin
                        if (byteCnt_q == LastByte) begin
                            txValid_q <= 1'b0;
                            state_q   <= StNext;
                        end else begin
                            byteCnt_q <= byteCnt_q + 4'd1;
                            txData_q  <= pickByte(dumpWord_q, byteCnt_q + 4'd1);
                        end
                    end
                end
                // Last byte is already in the shifter, so the next fetch overlaps its frame.
                StNext: begin
                    if (regAddr == LastAddr) begin
                        state_q <= StFinish;
                    end else begin
                        regAddr <= regAddr + 5'd1;
                        state_q <= StSetAddr;
                    end
                end
                StFinish: begin
                    if (txIdle) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sm_regdump_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .txValid_i (txValid_q),
        .txData_i  (txData_q),
        .txReady_o (txReady),
        .txIdle_o  (txIdle),
        .txLine_o  (uart_tx)
    );

endmodule

// File: tb/tb_sm_regdump_uart.sv
// Bench for sm_regdump_uart: three instances (regs 1, 30..31, 2) at CLK_DIV=4, line waveform
// compared sample-by-sample against frames built from a small register/formatting model.
module tb_sm_regdump_uart;

    localparam int Div        = 4;
    localparam int MaxSamples = 1024;
`ifdef SM_REGDUMP_HEX_EN
    localparam int Bpr = 10;
`else
    localparam int Bpr = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        startW [3];
    logic [4:0]  addrW  [3];
    logic [31:0] dataW  [3];
    logic        txW    [3];
    logic        busyW  [3];
    logic        doneW  [3];

    logic        lineS [MaxSamples];
    logic        busyS [MaxSamples];
    logic        doneS [MaxSamples];
    logic [4:0]  addrS [MaxSamples];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] regModel(input logic [4:0] a);
        case (a)
            5'd1:    return 32'h1234_5678;
            5'd2:    return 32'h00AB_CDEF;
            5'd30:   return 32'hDEAD_BEEF;
            5'd31:   return 32'hC0FF_EE01;
            default: return 32'hA500_0000 | {27'h0, a};
        endcase
    endfunction

    function automatic logic [7:0] expByte(input logic [31:0] v, input int i);
`ifdef SM_REGDUMP_HEX_EN
        string digits = "0123456789ABCDEF";
        logic [3:0] n;
        if (i == 8) return 8'h0D;
        if (i == 9) return 8'h0A;
        n = v[31-4*i -: 4];
        return digits[n];
`else
        return v[31-8*i -: 8];
`endif
    endfunction

    assign dataW[0] = regModel(addrW[0]);
    assign dataW[1] = regModel(addrW[1]);
    assign dataW[2] = regModel(addrW[2]);

    sm_regdump_uart #(.CLK_DIV(Div), .FIRST_REG(1), .LAST_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(startW[0]), .regAddr(addrW[0]), .regData(dataW[0]),
        .uart_tx(txW[0]), .busy(busyW[0]), .done(doneW[0])
    );
    sm_regdump_uart #(.CLK_DIV(Div), .FIRST_REG(30), .LAST_REG(31)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(startW[1]), .regAddr(addrW[1]), .regData(dataW[1]),
        .uart_tx(txW[1]), .busy(busyW[1]), .done(doneW[1])
    );
    sm_regdump_uart #(.CLK_DIV(Div), .FIRST_REG(2), .LAST_REG(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(startW[2]), .regAddr(addrW[2]), .regData(dataW[2]),
        .uart_tx(txW[2]), .busy(busyW[2]), .done(doneW[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int sel;
        int first;
        int nRegs;
        int midStart;
        int expFrames;
        int expLastAddr;
    } vec_t;

    // Sample j is taken on the negedge after the (j)th posedge following start acceptance.
    task automatic runDump(input vec_t v, input string tag);
        int doneIdx, doneCnt, last, bad, endIdx;
        logic [7:0] b;
        logic bv;
        doneIdx = -1;
        doneCnt = 0;
        last    = -1;
        @(negedge clk);
        startW[v.sel] = 1'b1;
        for (int j = 0; j < MaxSamples; j++) begin
            @(negedge clk);
            lineS[j] = txW[v.sel];
            busyS[j] = busyW[v.sel];
            doneS[j] = doneW[v.sel];
            addrS[j] = addrW[v.sel];
            startW[v.sel] = (v.midStart != 0 && j == v.midStart);
            if (doneS[j]) begin
                doneCnt++;
                if (doneIdx < 0) doneIdx = j;
            end
            last = j;
            if (doneIdx >= 0 && j >= doneIdx + 2) break;
        end
        startW[v.sel] = 1'b0;
        endIdx = 2 + v.expFrames * 10 * Div;
        if (doneIdx < 0) begin
            check({tag, "_timeout"}, 32'(last), 32'(endIdx));
            return;
        end
        check({tag, "_busy_at_accept"}, 32'(busyS[0]), 32'd1);
        check({tag, "_addr_first"}, 32'(addrS[0]), 32'(v.first));
        check({tag, "_line_before_start"}, 32'(lineS[1]), 32'd1);
        for (int f = 0; f < v.expFrames; f++) begin
            bad = 0;
            b = expByte(regModel(5'(v.first + f / Bpr)), f % Bpr);
            for (int t = 0; t < 10; t++) begin
                bv = (t == 0) ? 1'b0 : (t == 9) ? 1'b1 : b[t-1];
                for (int c = 0; c < Div; c++)
                    if (lineS[2 + 10*Div*f + Div*t + c] !== bv) bad++;
            end
            check($sformatf("%s_frame%0d_bad_samples(byte 0x%02h)", tag, f, b), 32'(bad), 0);
            check($sformatf("%s_frame%0d_addr", tag, f), 32'(addrS[2 + 10*Div*f]),
                  32'(v.first + f / Bpr));
        end
        bad = 0;
        for (int j = 0; j <= doneIdx; j++)
            if (addrS[j] < 5'(v.first) || addrS[j] > 5'(v.expLastAddr)) bad++;
        check({tag, "_addr_out_of_range"}, 32'(bad), 0);
        check({tag, "_addr_last"}, 32'(addrS[doneIdx]), 32'(v.expLastAddr));
        check({tag, "_line_idle_after"}, 32'(lineS[endIdx]), 32'd1);
        check({tag, "_done_count"}, 32'(doneCnt), 32'd1);
        check({tag, "_done_after_stop"},
              32'(doneIdx >= endIdx && doneIdx <= endIdx + 2), 32'd1);
        bad = 0;
        for (int j = 0; j < doneIdx; j++) if (busyS[j] !== 1'b1) bad++;
        check({tag, "_busy_drop"}, 32'(bad), 0);
        check({tag, "_busy_low_at_done"}, 32'(busyS[doneIdx]), 32'd0);
    endtask

    vec_t vecs [4];
    int   waited;

    initial begin
        for (int i = 0; i < 3; i++) startW[i] = 1'b0;
        vecs[0] = '{sel: 0, first: 1,  nRegs: 1, midStart: 0,   expFrames: Bpr,
                    expLastAddr: 1};
        vecs[1] = '{sel: 1, first: 30, nRegs: 2, midStart: 0,   expFrames: 2*Bpr,
                    expLastAddr: 31};
        vecs[2] = '{sel: 1, first: 30, nRegs: 2, midStart: 100, expFrames: 2*Bpr,
                    expLastAddr: 31};
        vecs[3] = '{sel: 2, first: 2,  nRegs: 1, midStart: 0,   expFrames: Bpr,
                    expLastAddr: 2};

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_tx%0d", i), 32'(txW[i]), 32'd1);
            check($sformatf("reset_busy%0d", i), 32'(busyW[i]), 32'd0);
            check($sformatf("reset_done%0d", i), 32'(doneW[i]), 32'd0);
            check($sformatf("reset_addr%0d", i), 32'(addrW[i]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 4; k++) runDump(vecs[k], $sformatf("vec%0d", k));

        // Reset during data bit 0 of the first frame (a low bit), then a clean dump.
        @(negedge clk);
        startW[0] = 1'b1;
        @(negedge clk);
        startW[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("midrst_line_low_before", 32'(txW[0]), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(txW[0]), 32'd1);
        check("midrst_busy", 32'(busyW[0]), 32'd0);
        check("midrst_done", 32'(doneW[0]), 32'd0);
        check("midrst_addr", 32'(addrW[0]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        runDump(vecs[0], "after_rst");

        // start held high: next dump is accepted on the edge right after the done pulse.
        @(negedge clk);
        startW[0] = 1'b1;
        waited = 0;
        while (doneW[0] !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("held_done_seen", 32'(doneW[0]), 32'd1);
        @(negedge clk);
        check("held_restart_busy", 32'(busyW[0]), 32'd1);
        startW[0] = 1'b0;
        waited = 0;
        while (busyW[0] !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("held_second_dump_ends", 32'(busyW[0]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
